// File: rtl/hgc_crt_timing.sv
// hgc_crt_timing: CRT raster timing generator (counters, syncs, active flag, line/frame pulses).
// Optional blink generator is compiled in when HGC_BLINK_EN is defined.
module hgc_crt_timing #(
    parameter int          HW           = 11,
    parameter int          VW           = 10,
    parameter int          H_ACTIVE     = 720,
    parameter int          H_TOTAL      = 910,
    parameter int          H_SYNC_START = 750,
    parameter int          H_SYNC_WIDTH = 120,
    parameter int          V_ACTIVE     = 350,
    parameter int          V_TOTAL      = 446,
    parameter int          V_SYNC_START = 380,
    parameter int          V_SYNC_WIDTH = 2,
    parameter logic        HSYNC_POL    = 1'b1,
    parameter logic        VSYNC_POL    = 1'b0,
    parameter logic [23:0] BLINK_MAX    = 24'd9100000
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          pll_lock,
    input  logic          enable,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          display_en,
    output logic          frame_start,
    output logic          line_start,
    output logic          blink
);
    if (H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_bad_param
        $error("hgc_crt_timing: H_TOTAL/V_TOTAL do not fit the counter widths");
    end

    logic          run;
    logic          h_wrap;
    logic          v_wrap;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          hs_next;
    logic          vs_next;
    logic          de_next;

    // Decode from the next counts so registered outputs line up with the counters.
    // Compares are 32-bit so sync windows ending at the last count never truncate.
    always_comb begin
        run     = pll_lock & enable;
        h_wrap  = 32'(hcount) == H_TOTAL - 1;
        v_wrap  = 32'(vcount) == V_TOTAL - 1;
        h_next  = h_wrap ? '0 : hcount + 1'b1;
        v_next  = h_wrap ? (v_wrap ? '0 : vcount + 1'b1) : vcount;
        hs_next = (32'(h_next) >= H_SYNC_START && 32'(h_next) < H_SYNC_START + H_SYNC_WIDTH)
                  ? HSYNC_POL : ~HSYNC_POL;
        vs_next = (32'(v_next) >= V_SYNC_START && 32'(v_next) < V_SYNC_START + V_SYNC_WIDTH)
                  ? VSYNC_POL : ~VSYNC_POL;
        de_next = 32'(h_next) < H_ACTIVE && 32'(v_next) < V_ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            display_en  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (run) begin
            hcount      <= h_next;
            vcount      <= v_next;
            hsync       <= hs_next;
            vsync       <= vs_next;
            display_en  <= de_next;
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef HGC_BLINK_EN
    logic [23:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (run) begin
            if (blink_cnt == BLINK_MAX - 24'd1) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 24'd1;
            end
        end
    end
`else
    assign blink = 1'b0;
`endif
endmodule

// File: doc/hgc_crt_timing.md
HGC_CRT_TIMING -- requirements
Module: hgc_crt_timing

Interface
REQ-001 SHALL have parameter HW, default 11, horizontal counter width.
REQ-002 SHALL have parameter VW, default 10, vertical counter width.
REQ-003 SHALL have parameters H_ACTIVE/H_TOTAL/H_SYNC_START/H_SYNC_WIDTH, defaults 720/910/750/120, in pixel clocks.
REQ-004 SHALL have parameters V_ACTIVE/V_TOTAL/V_SYNC_START/V_SYNC_WIDTH, defaults 350/446/380/2, in lines.
REQ-005 SHALL have parameters HSYNC_POL/VSYNC_POL, default 1/0, active level of each sync output.
REQ-006 SHALL have parameter BLINK_MAX, 24 bits, default 24'd9100000, blink half-period in frames-independent clocks.
REQ-007 SHALL have ports: clk input 1, pixel clock; reset_l input 1, synchronous active-low reset.
REQ-008 SHALL have ports: pll_lock input 1, clock-valid qualifier; enable input 1, timing run enable.
REQ-009 SHALL have ports: hcount output HW, vcount output VW, current position.
REQ-010 SHALL have ports: hsync output 1, vsync output 1, display_en output 1, active-region flag.
REQ-011 SHALL have ports: frame_start output 1, one-clock pulse; line_start output 1, one-clock pulse; blink output 1.

Function
REQ-012 SHALL advance only when run = pll_lock & enable; when run=0 all counters and outputs hold.
REQ-013 SHALL increment hcount each run clock, wrapping H_TOTAL-1 -> 0.
REQ-014 SHALL increment vcount exactly on hcount wrap, wrapping V_TOTAL-1 -> 0 (simultaneous wraps in one clock).
REQ-015 SHALL assert hsync=HSYNC_POL while H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_WIDTH, else inverse.
REQ-016 SHALL assert vsync=VSYNC_POL while V_SYNC_START <= vcount < V_SYNC_START+V_SYNC_WIDTH, else inverse.
REQ-017 SHALL assert display_en while hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-018 SHALL register hsync/vsync/display_en: each reflects the count values present in the same cycle as hcount/vcount (decode from next-count values; zero added latency relative to counters).
REQ-019 SHALL pulse line_start one clock when hcount becomes 0, frame_start one clock when hcount and vcount both become 0.
REQ-020 SHALL not pulse line_start/frame_start while run=0, and SHALL pulse at most once per wrap even if run toggles.
REQ-021 SHALL compute sync end as full-width compare (no truncation) so sync windows touching H_TOTAL-1 or V_TOTAL-1 are correct.
REQ-022 SHALL hold counters at a legal value if parameters give H_TOTAL > 2^HW or V_TOTAL > 2^VW: synthesis-time error required instead.

Reset
REQ-023 SHALL on reset_l=0 at a clk edge set hcount=0, vcount=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, display_en=0, line_start=0, frame_start=0, blink=0, blink counter=0.
REQ-024 SHALL give reset priority over run; reset mid-line restarts at hcount=0 with no frame_start pulse on that cycle.
REQ-025 SHALL emit first frame_start on the first run clock wrap after reset, not at reset release.

Configuration
REQ-026 SHALL compile the blink generator only when macro HGC_BLINK_EN is defined: 24-bit counter counts run clocks, at BLINK_MAX-1 clears and toggles blink.
REQ-027 SHALL, without HGC_BLINK_EN, tie blink to 0 and instantiate no blink counter.

Verification
REQ-028 SHALL cover: reset release, run=1, defaults -> first line_start at clock 910, hsync active (1) for hcount 750..869 exactly.
REQ-029 SHALL cover: full frame -> frame_start every 910*446=405860 clocks, vsync low for vcount 380..381 only.
REQ-030 SHALL cover: pll_lock=0 for 100 clocks at hcount=500 -> hcount stays 500, no pulses; resumes at 501.
REQ-031 SHALL cover: reset_l=0 at hcount=909, vcount=445 -> next cycle counts 0/0, frame_start=0.
REQ-032 SHALL cover: HGC_BLINK_EN defined, BLINK_MAX=4 -> blink toggles every 4 run clocks; undefined -> blink constant 0.
REQ-033 SHALL cover: display_en high exactly 720*350=252000 clocks per frame.
